// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the pattern bank serializer
package seq_pkg;

    localparam int SEQ_WIDTH = 10;
    localparam int SEQ_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Index width for a range of n items, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_bank_serializer_edge_rise.sv
// rtl/seq_bank_serializer_edge_rise.sv - one-cycle rising-edge pulse for a synchronised button
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = btn;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/seq_bank_serializer.sv
// rtl/seq_bank_serializer.sv - switch pattern bank with serial replay into the sequence detector
module seq_bank_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH,
    parameter int DEPTH     = SEQ_DEPTH,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1,
    localparam int SW       = sel_width(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_btn,
    input  logic             play_btn,
    input  logic [SW-1:0]    sel,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] sequence_out,
    output logic [CW-1:0]    count,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int DW = sel_width(DIV);
    localparam int BW = sel_width(WIDTH);

    logic load_rise;
    logic play_rise;

    edge_rise u_load_edge (.clk(clk), .rst(rst), .btn(load_btn), .rise(load_rise));
    edge_rise u_play_edge (.clk(clk), .rst(rst), .btn(play_btn), .rise(play_rise));

    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];
    logic [SW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic [DW-1:0]    div_q, div_d;

    // Loads are independent of the FSM; once full the oldest slot is overwritten.
    always_comb begin
        bank_d   = bank_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (load_rise) begin
            bank_d[wr_ptr_q] = switches;
            wr_ptr_d = (wr_ptr_q == SW'(DEPTH - 1)) ? '0 : wr_ptr_q + SW'(1);
            count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
        end
    end

    // Play reads bank_q and count_q, so a same-edge load is invisible to it.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        div_d     = div_q;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (play_rise && (CW'(sel) < count_q)) begin
                    shreg_d   = bank_q[sel];
                    bit_idx_d = '0;
                    div_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                bit_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                bit_valid = (div_q == '0);
                if (div_q == DW'(DIV - 1)) begin
                    div_d   = '0;
                    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                    if (bit_idx_q == BW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            div_q     <= '0;
        end else begin
            bank_q    <= bank_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            div_q     <= div_d;
        end
    end

    assign sequence_out = bank_q[sel];
    assign count        = count_q;

endmodule

// File: tb/tb_seq_bank_serializer.sv
// tb/tb_seq_bank_serializer.sv - randomized self-checking bench for seq_bank_serializer
module tb_seq_bank_serializer;

    localparam int W  = 10;
    localparam int D  = 4;
    localparam int SW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_btn = 1'b0;
    logic          play_btn = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [W-1:0]  switches = '0;

    logic [W-1:0]  seq_a, seq_b;
    logic [CW-1:0] cnt_a, cnt_b;
    logic          bo_a, bv_a, busy_a, done_a;
    logic          bo_b, bv_b, busy_b, done_b;

    seq_bank_serializer #(.WIDTH(W), .DEPTH(D), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .load_btn(load_btn), .play_btn(play_btn), .sel(sel),
        .switches(switches), .sequence_out(seq_a), .count(cnt_a), .bit_out(bo_a),
        .bit_valid(bv_a), .busy(busy_a), .done(done_a));

    seq_bank_serializer #(.WIDTH(W), .DEPTH(D), .DIV(3), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .load_btn(load_btn), .play_btn(play_btn), .sel(sel),
        .switches(switches), .sequence_out(seq_b), .count(cnt_b), .bit_out(bo_b),
        .bit_valid(bv_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit bits_a[$];
    bit bits_b[$];
    int stamp_b[$];
    int nbusy_a, nbusy_b, ndone_a, ndone_b;
    int last_busy_a, done_at_a, last_busy_b, done_at_b;

    always @(negedge clk) begin
        if (bv_a) bits_a.push_back(bo_a);
        if (bv_b) begin
            bits_b.push_back(bo_b);
            stamp_b.push_back(cyc);
        end
        if (busy_a) begin nbusy_a++; last_busy_a = cyc; end
        if (busy_b) begin nbusy_b++; last_busy_b = cyc; end
        if (done_a) begin ndone_a++; done_at_a = cyc; end
        if (done_b) begin ndone_b++; done_at_b = cyc; end
    end

    // Reference bank: a ring of DEPTH slots with a saturating fill count.
    logic [W-1:0] m_bank [D];
    int m_count, m_wr;

    task automatic m_reset();
        for (int i = 0; i < D; i++) m_bank[i] = '0;
        m_count = 0;
        m_wr = 0;
    endtask

    task automatic m_load(input logic [W-1:0] p);
        m_bank[m_wr] = p;
        m_wr = (m_wr + 1) % D;
        if (m_count < D) m_count++;
    endtask

    function automatic logic [W-1:0] q2word(input bit q[$], input bit msb);
        logic [W-1:0] w = '0;
        for (int i = 0; i < q.size() && i < W; i++) begin
            if (msb) w[W-1-i] = q[i];
            else     w[i] = q[i];
        end
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        bits_a.delete(); bits_b.delete(); stamp_b.delete();
        nbusy_a = 0; nbusy_b = 0; ndone_a = 0; ndone_b = 0;
        last_busy_a = -10; last_busy_b = -10; done_at_a = -20; done_at_b = -20;
    endtask

    task automatic do_reset();
        rst = 1'b0; load_btn = 1'b0; play_btn = 1'b0;
        tick(2);
        rst = 1'b1;
        m_reset();
        clear_mon();
    endtask

    task automatic press_load(input logic [W-1:0] p, input int hold);
        switches = p;
        load_btn = 1'b1;
        tick(hold);
        load_btn = 1'b0;
        tick(1);
        m_load(p);
    endtask

    task automatic press_play(input logic [SW-1:0] s);
        sel = s;
        play_btn = 1'b1;
        tick(1);
        play_btn = 1'b0;
        tick(1);
    endtask

    task automatic wait_streams();
        int n = 0;
        while ((busy_a || busy_b || done_a || done_b) && n < 200) begin
            tick(1);
            n++;
        end
        tick(1);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_streams: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({cnt_a, seq_a, bo_a, bv_a, busy_a, done_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: count=%0d seq=%h bo=%b bv=%b busy=%b done=%b, required all 0",
                     cnt_a, seq_a, bo_a, bv_a, busy_a, done_a);
        end
        tick(1);
        press_play(0);
        tick(4);
        checks++;
        if (nbusy_a != 0 || nbusy_b != 0) begin
            errors++;
            $display("FAIL reset_play_empty: busy cycles a=%0d b=%0d, required 0", nbusy_a, nbusy_b);
        end
    endtask

    task automatic test_basic(input logic [W-1:0] p);
        do_reset();
        press_load(p, 5);
        checks++;
        if (cnt_a !== CW'(1)) begin
            errors++;
            $display("FAIL basic_count: count=%0d, required 1", cnt_a);
        end
        clear_mon();
        sel = 0;
        play_btn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_busy: busy=%b, required 0", busy_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || bv_a !== 1'b1 || bo_a !== p[W-1]) begin
            errors++;
            $display("FAIL basic_latency: busy=%b bv=%b bo=%b, required 1 1 %b", busy_a, bv_a, bo_a, p[W-1]);
        end
        #1;
        play_btn = 1'b0;
        tick(1);
        wait_streams();
        checks++;
        if (bits_a.size() != W || q2word(bits_a, 1'b1) !== p) begin
            errors++;
            $display("FAIL basic_stream_a: %0d bits word=%b, required %0d bits %b",
                     bits_a.size(), q2word(bits_a, 1'b1), W, p);
        end
        checks++;
        if (bits_b.size() != W || q2word(bits_b, 1'b0) !== p) begin
            errors++;
            $display("FAIL basic_stream_b: %0d bits word=%b, required %0d bits %b",
                     bits_b.size(), q2word(bits_b, 1'b0), W, p);
        end
        checks++;
        if (nbusy_a != W || nbusy_b != 3 * W) begin
            errors++;
            $display("FAIL basic_busy_len: a=%0d b=%0d, required %0d %0d", nbusy_a, nbusy_b, W, 3 * W);
        end
        checks++;
        if (ndone_a != 1 || ndone_b != 1 || done_at_a != last_busy_a + 1 || done_at_b != last_busy_b + 1) begin
            errors++;
            $display("FAIL basic_done: counts a=%0d b=%0d offsets a=%0d b=%0d, required 1 1 1 1",
                     ndone_a, ndone_b, done_at_a - last_busy_a, done_at_b - last_busy_b);
        end
        for (int i = 1; i < stamp_b.size(); i++) begin
            checks++;
            if (stamp_b[i] - stamp_b[i-1] != 3) begin
                errors++;
                $display("FAIL div3_spacing: bit %0d gap=%0d, required 3", i, stamp_b[i] - stamp_b[i-1]);
            end
        end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 1; i <= 5; i++) press_load(W'(i), 2);
        checks++;
        if (cnt_a !== CW'(4) || cnt_b !== CW'(4)) begin
            errors++;
            $display("FAIL wrap_count: a=%0d b=%0d, required 4", cnt_a, cnt_b);
        end
        for (int s = 0; s < D; s++) begin
            sel = SW'(s);
            #1;
            checks++;
            if (seq_a !== ((s == 0) ? W'(5) : W'(s + 1)) || seq_a !== m_bank[s]) begin
                errors++;
                $display("FAIL wrap_slot%0d: seq=%h, required %h", s, seq_a, (s == 0) ? 5 : s + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [SW-1:0] s;
        do_reset();
        for (int it = 0; it < 8; it++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) press_load(W'($urandom), $urandom_range(1, 3));
            s = SW'($urandom_range(0, D - 1));
            clear_mon();
            press_play(s);
            wait_streams();
            checks++;
            if (seq_a !== m_bank[s] || cnt_a !== CW'(m_count)) begin
                errors++;
                $display("FAIL rand_bank it%0d: seq=%h count=%0d, required %h %0d",
                         it, seq_a, cnt_a, m_bank[s], m_count);
            end
            checks++;
            if (int'(s) < m_count) begin
                if (q2word(bits_a, 1'b1) !== m_bank[s] || q2word(bits_b, 1'b0) !== m_bank[s] ||
                    bits_a.size() != W || bits_b.size() != W) begin
                    errors++;
                    $display("FAIL rand_stream it%0d: a=%b b=%b, required %b",
                             it, q2word(bits_a, 1'b1), q2word(bits_b, 1'b0), m_bank[s]);
                end
            end else if (nbusy_a != 0 || nbusy_b != 0 || ndone_a != 0) begin
                errors++;
                $display("FAIL rand_ignored it%0d: busy a=%0d b=%0d, required 0", it, nbusy_a, nbusy_b);
            end
        end
    endtask

    task automatic test_play_during_shift();
        logic [SW-1:0] s;
        logic [W-1:0] old_p, new_p;
        do_reset();
        for (int i = 0; i < D; i++) press_load(W'($urandom), 1);
        s = SW'(m_wr);
        old_p = m_bank[s];
        new_p = ~old_p;
        clear_mon();
        press_play(s);
        tick(2);
        press_load(new_p, 2);
        press_play(s);
        wait_streams();
        checks++;
        if (q2word(bits_a, 1'b1) !== old_p || q2word(bits_b, 1'b0) !== old_p || ndone_a != 1 || nbusy_a != W) begin
            errors++;
            $display("FAIL shift_interference: a=%b b=%b done=%0d busy=%0d, required %b 1 %0d",
                     q2word(bits_a, 1'b1), q2word(bits_b, 1'b0), ndone_a, nbusy_a, old_p, W);
        end
        clear_mon();
        press_play(s);
        wait_streams();
        checks++;
        if (q2word(bits_a, 1'b1) !== new_p || q2word(bits_b, 1'b0) !== new_p) begin
            errors++;
            $display("FAIL shift_next_play: a=%b b=%b, required %b", q2word(bits_a, 1'b1), q2word(bits_b, 1'b0), new_p);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        press_load(W'($urandom), 1);
        press_play(0);
        while (bits_a.size() < 4 && n < 50) begin
            tick(1);
            n++;
        end
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        checks++;
        if (busy_a || busy_b || done_a || done_b || bo_a || bv_a || cnt_a !== '0 || cnt_b !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b%b done=%b%b bo=%b bv=%b count=%0d, required all 0",
                     busy_a, busy_b, done_a, done_b, bo_a, bv_a, cnt_a);
        end
        tick(40);
        checks++;
        if (ndone_a != 0 || ndone_b != 0) begin
            errors++;
            $display("FAIL reset_mid_done: done pulses a=%0d b=%0d, required 0", ndone_a, ndone_b);
        end
    endtask

    task automatic test_same_edge();
        logic [SW-1:0] s;
        logic [W-1:0] old_p, new_p;
        do_reset();
        for (int i = 0; i < D; i++) press_load(W'($urandom), 1);
        s = SW'(m_wr);
        old_p = m_bank[s];
        new_p = W'($urandom) ^ old_p ^ W'(1);
        clear_mon();
        sel = s; switches = new_p;
        load_btn = 1'b1; play_btn = 1'b1;
        tick(2);
        load_btn = 1'b0; play_btn = 1'b0;
        tick(1);
        m_load(new_p);
        wait_streams();
        checks++;
        if (q2word(bits_a, 1'b1) !== old_p || q2word(bits_b, 1'b0) !== old_p || seq_a !== new_p) begin
            errors++;
            $display("FAIL same_edge_stream: a=%b b=%b seq=%b, required stream %b seq %b",
                     q2word(bits_a, 1'b1), q2word(bits_b, 1'b0), seq_a, old_p, new_p);
        end
        do_reset();
        press_load(W'($urandom), 1);
        sel = SW'(1); switches = W'($urandom);
        load_btn = 1'b1; play_btn = 1'b1;
        tick(1);
        load_btn = 1'b0; play_btn = 1'b0;
        tick(1);
        m_load(switches);
        tick(3);
        checks++;
        if (nbusy_a != 0 || nbusy_b != 0 || cnt_a !== CW'(m_count)) begin
            errors++;
            $display("FAIL same_edge_old_count: busy a=%0d b=%0d count=%0d, required 0 0 %0d",
                     nbusy_a, nbusy_b, cnt_a, m_count);
        end
    endtask

    initial begin
        clear_mon();
        m_reset();
        test_reset();
        test_basic(10'b1011001110);
        test_basic(10'b0000000011);
        test_fill_wrap();
        test_random();
        test_play_during_shift();
        test_reset_mid();
        test_same_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
